// File: rtl/score_seg_595_if.sv
// Pin bundle of the score/timer display: game-side inputs plus the four 74HC595 control pins.
// master drives the game inputs and observes the pins; slave is the display driver.
interface score_seg_595_if;
    logic [7:0] bcd_data;
    logic       clear_signal;
    logic       start_signal;
    logic       stcp;
    logic       shcp;
    logic       ds;
    logic       oe;

    modport master (
        output bcd_data, clear_signal, start_signal,
        input  stcp, shcp, ds, oe
    );

    modport slave (
        input  bcd_data, clear_signal, start_signal,
        output stcp, shcp, ds, oe
    );
endinterface

// File: rtl/score_seg_595_top.sv
// 6-digit score/timer display driven serially through two cascaded 74HC595s.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros of the timer digits.
module score_seg_595_top #(
    parameter int unsigned DATA_CNT_MAX = 32'd49_999_999,
    parameter int unsigned SCAN_CNT_MAX = 32'd49_999
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    score_seg_595_if.slave bus
);
    localparam int unsigned DATA_W = (DATA_CNT_MAX > 32'd0) ? $clog2(DATA_CNT_MAX + 32'd1) : 32'd1;
    localparam int unsigned SCAN_W = (SCAN_CNT_MAX > 32'd0) ? $clog2(SCAN_CNT_MAX + 32'd1) : 32'd1;

    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [15:0] r;
        logic        carry;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                carry = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    logic [DATA_W-1:0] data_cnt_q, data_cnt_d;
    logic [15:0]       timer_q, timer_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]        digit_idx_q, digit_idx_d;
    logic [1:0]        cnt4_q, cnt4_d;
    logic [3:0]        cnt_bit_q, cnt_bit_d;
    logic [13:0]       frame_q, frame_d;
    logic              ds_q, ds_d;
    logic              shcp_q, shcp_d;
    logic              stcp_q, stcp_d;
    logic              oe_q, oe_d;

    logic [3:0]        digit_s;
    logic              blank_s;
    logic [7:0]        seg_s;
    logic [5:0]        sel_s;
    logic [13:0]       frame_now_s;
    logic [13:0]       frame_src_s;

    // Current digit's segment/select pattern, packed in shift order (seg a first, sel[0] last)
    always_comb begin
        digit_s     = 4'hF;
        blank_s     = 1'b0;
        frame_now_s = 14'd0;
        case (digit_idx_q)
            3'd0:    digit_s = bus.bcd_data[7:4];
            3'd1:    digit_s = bus.bcd_data[3:0];
            3'd2:    digit_s = timer_q[15:12];
            3'd3:    digit_s = timer_q[11:8];
            3'd4:    digit_s = timer_q[7:4];
            3'd5:    digit_s = timer_q[3:0];
            default: digit_s = 4'hF;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        case (digit_idx_q)
            3'd2:    blank_s = (timer_q[15:12] == 4'd0);
            3'd3:    blank_s = (timer_q[15:8] == 8'd0);
            3'd4:    blank_s = (timer_q[15:4] == 12'd0);
            default: blank_s = 1'b0;
        endcase
`else
        blank_s = 1'b0;
`endif
        if (blank_s) begin
            seg_s = 8'hFF;
        end else begin
            seg_s = seg_of(digit_s);
        end
        // dp separates score from time
        if (digit_idx_q == 3'd1) begin
            seg_s[7] = 1'b0;
        end else begin
            seg_s[7] = seg_s[7];
        end
        sel_s = 6'b000001 << digit_idx_q;
        frame_now_s[7:0] = seg_s;
        for (int k = 0; k < 6; k++) begin
            frame_now_s[8 + k] = sel_s[5 - k];
        end
        if (cnt_bit_q == 4'd0) begin
            frame_src_s = frame_now_s;
        end else begin
            frame_src_s = frame_q;
        end
    end

    // Next state of timer, digit scan and 595 serialiser
    always_comb begin
        data_cnt_d  = data_cnt_q;
        timer_d     = timer_q;
        scan_cnt_d  = scan_cnt_q;
        digit_idx_d = digit_idx_q;
        cnt4_d      = cnt4_q + 2'd1;
        cnt_bit_d   = cnt_bit_q;
        frame_d     = frame_q;
        ds_d        = ds_q;
        shcp_d      = shcp_q;
        stcp_d      = 1'b0;
        oe_d        = 1'b0;

        if (bus.clear_signal) begin
            data_cnt_d = {DATA_W{1'b0}};
            timer_d    = 16'h0000;
        end else if (bus.start_signal) begin
            if (data_cnt_q == DATA_W'(DATA_CNT_MAX)) begin
                data_cnt_d = {DATA_W{1'b0}};
                timer_d    = bcd_inc(timer_q);
            end else begin
                data_cnt_d = data_cnt_q + {{(DATA_W-1){1'b0}}, 1'b1};
            end
        end else begin
            data_cnt_d = data_cnt_q;
        end

        if (scan_cnt_q == SCAN_W'(SCAN_CNT_MAX)) begin
            scan_cnt_d  = {SCAN_W{1'b0}};
            digit_idx_d = (digit_idx_q == 3'd5) ? 3'd0 : digit_idx_q + 3'd1;
        end else begin
            scan_cnt_d  = scan_cnt_q + {{(SCAN_W-1){1'b0}}, 1'b1};
        end

        if (cnt4_q == 2'd3) begin
            cnt_bit_d = (cnt_bit_q == 4'd13) ? 4'd0 : cnt_bit_q + 4'd1;
        end else begin
            cnt_bit_d = cnt_bit_q;
        end

        // Frame is frozen at its start so a mid-frame digit change waits for the next frame
        if ((cnt_bit_q == 4'd0) && (cnt4_q == 2'd0)) begin
            frame_d = frame_now_s;
        end else begin
            frame_d = frame_q;
        end

        case (cnt4_q)
            2'd0: begin
                ds_d   = frame_src_s[cnt_bit_q];
                shcp_d = 1'b0;
            end
            2'd2:    shcp_d = 1'b1;
            default: shcp_d = shcp_q;
        endcase

        stcp_d = (cnt_bit_q == 4'd13) && (cnt4_q == 2'd3);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            data_cnt_q  <= {DATA_W{1'b0}};
            timer_q     <= 16'h0000;
            scan_cnt_q  <= {SCAN_W{1'b0}};
            digit_idx_q <= 3'd0;
            cnt4_q      <= 2'd0;
            cnt_bit_q   <= 4'd0;
            frame_q     <= 14'd0;
            ds_q        <= 1'b0;
            shcp_q      <= 1'b0;
            stcp_q      <= 1'b0;
            oe_q        <= 1'b1;
        end else begin
            data_cnt_q  <= data_cnt_d;
            timer_q     <= timer_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            cnt4_q      <= cnt4_d;
            cnt_bit_q   <= cnt_bit_d;
            frame_q     <= frame_d;
            ds_q        <= ds_d;
            shcp_q      <= shcp_d;
            stcp_q      <= stcp_d;
            oe_q        <= oe_d;
        end
    end

    assign bus.ds   = ds_q;
    assign bus.shcp = shcp_q;
    assign bus.stcp = stcp_q;
    assign bus.oe   = oe_q;
endmodule

// File: tb/tb_score_seg_595_top.sv
// Bench for score_seg_595_top: integer-level display model checked against the 595 pins every cycle,
// plus directed checks on frames reassembled from the serial stream.
module tb_score_seg_595_top;
    localparam int DCM = 49;
    localparam int SCM = 19;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   printed  = 0;

    score_seg_595_if bus();

    score_seg_595_top #(.DATA_CNT_MAX(DCM), .SCAN_CNT_MAX(SCM)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    always #10 clk = ~clk;

    // ---------------- model ----------------
    bit          live = 1'b0;
    int          mj = 0;      // clock edges since reset release
    int          mp = 0;      // prescaler
    int          mt = 0;      // timer as integer 0..9999
    logic [13:0] mframe = 14'd0;
    int          force_seq = 0;
    int          force_val = 0;
    int          seen_seq = 0;

    function automatic logic [7:0] enc(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [13:0] frame_of(input int idx, input int t, input logic [7:0] b);
        int          d;
        logic [7:0]  s;
        logic [5:0]  sel;
        logic [13:0] f;
        case (idx)
            0: d = int'(b[7:4]);
            1: d = int'(b[3:0]);
            2: d = (t / 1000) % 10;
            3: d = (t / 100) % 10;
            4: d = (t / 10) % 10;
            default: d = t % 10;
        endcase
        s = enc(d);
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx == 2 && t < 1000) || (idx == 3 && t < 100) || (idx == 4 && t < 10)) s = 8'hFF;
`endif
        if (idx == 1) s[7] = 1'b0;
        sel = 6'd0;
        sel[idx] = 1'b1;
        f[7:0] = s;
        for (int k = 0; k < 6; k++) f[8 + k] = sel[5 - k];
        return f;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mj = 0; mp = 0; mt = 0; mframe = 14'd0; live = 1'b1;
        end else begin
            if (force_seq != seen_seq) begin
                mt = force_val;
                seen_seq = force_seq;
            end
            if (mj % 56 == 0) mframe = frame_of((mj / SCM_P1()) % 6, mt, bus.bcd_data);
            if (bus.clear_signal) begin
                mp = 0; mt = 0;
            end else if (bus.start_signal) begin
                if (mp == DCM) begin
                    mp = 0; mt = (mt + 1) % 10000;
                end else begin
                    mp = mp + 1;
                end
            end
            mj = mj + 1;
        end
    end

    function automatic int SCM_P1();
        return SCM + 1;
    endfunction

    // ---------------- checking / capture ----------------
    logic        prev_shcp = 1'b0;
    logic [13:0] rx = 14'd0;
    logic [13:0] last_rx = 14'd0;
    int          nframes = 0;

    task automatic tick();
        logic [3:0] want, got;
        @(negedge clk);
        if (live) begin
            if (mj == 0) want = 4'b1000;
            else want = {1'b0, ((mj - 1) % 56 == 55), ((mj - 1) % 4 >= 2), mframe[((mj - 1) / 4) % 14]};
            got = {bus.oe, bus.stcp, bus.shcp, bus.ds};
            checks++;
            if (got !== want) begin
                failures++;
                if (printed < 20) begin
                    printed++;
                    $display("FAIL pins edge=%0d got oe/stcp/shcp/ds=%b want=%b", mj, got, want);
                end
            end
        end
        if (bus.shcp === 1'b1 && prev_shcp === 1'b0) rx = {bus.ds, rx[13:1]};
        prev_shcp = bus.shcp;
        if (bus.stcp === 1'b1) begin
            last_rx = rx;
            nframes++;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic check_seg(input string name, input int idx, input logic [7:0] want);
        int          n0;
        bit          ok;
        logic [5:0]  sel;
        n0 = nframes;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            tick();
            if (nframes != n0) begin
                n0 = nframes;
                for (int k = 0; k < 6; k++) sel[k] = last_rx[13 - k];
                if (sel == (6'd1 << idx)) ok = 1'b1;
            end
        end
        checks++;
        if (!ok || last_rx[7:0] !== want) begin
            failures++;
            $display("FAIL %s digit%0d found=%0d got=%h want=%h", name, idx, ok, last_rx[7:0], want);
        end
    endtask

    task automatic force_timer(input logic [15:0] v, input int iv);
        force dut.timer_q = v;
        force_val = iv;
        force_seq++;
        tick();
        release dut.timer_q;
        tick();
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ = 8'hFF;
`else
    localparam logic [7:0] LZ = 8'hC0;
`endif

    initial begin
        int n;
        bus.bcd_data     = 8'h01;
        bus.start_signal = 1'b1;
        bus.clear_signal = 1'b0;
        rst_n            = 1'b0;
        repeat (5) tick();
        check("rst_pins", {bus.oe, bus.stcp, bus.shcp, bus.ds}, 4'b1000);
        rst_n = 1'b1;
        tick();
        check("oe_release", bus.oe, 1'b0);
        n = 1;
        while (bus.stcp !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("stcp_latency", n, 56);
        check("first_frame", last_rx, 14'b100000_11000000);

        // 600 counting edges in total -> 0012
        repeat (600 - n) tick();
        bus.start_signal = 1'b0;
        check("model_t12", mt, 12);
        check_seg("t0_two", 5, 8'hA4);
        check_seg("t1_one", 4, 8'hF9);
        check_seg("t2_lead", 3, LZ);
        repeat (300) tick();
        check("model_hold", mt, 12);
        check_seg("t0_hold", 5, 8'hA4);

        // clear has priority over start
        bus.start_signal = 1'b1;
        bus.clear_signal = 1'b1;
        repeat (10) tick();
        check("model_clear", mt, 0);
        check_seg("t0_clear", 5, 8'hC0);
        bus.clear_signal = 1'b0;
        repeat (100) tick();
        bus.start_signal = 1'b0;
        check("model_resume", mt, 2);

        // wrap 9999 -> 0000
        force_timer(16'h9999, 9999);
        check_seg("t3_nine", 2, 8'h90);
        bus.start_signal = 1'b1;
        repeat (50) tick();
        bus.start_signal = 1'b0;
        check("model_wrap", mt, 0);
        check_seg("t0_wrap", 5, 8'hC0);
        check_seg("t3_wrap", 2, LZ);

        // score digits with an out-of-range nibble
        bus.bcd_data = 8'h3A;
        check_seg("score_tens", 0, 8'hB0);
        check_seg("score_blank_dp", 1, 8'h7F);
        force_timer(16'h0007, 7);
        check_seg("t3_0007", 2, LZ);
        check_seg("t2_0007", 3, LZ);
        check_seg("t1_0007", 4, LZ);
        check_seg("t0_0007", 5, 8'hF8);

        // reset mid-frame restarts at digit 0
        repeat (13) tick();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        n = nframes;
        for (int i = 0; i < 200 && nframes == n; i++) tick();
        check("rst_frame", last_rx, 14'b100000_10110000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
